// File: rtl/miriscv_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/LSU unified-memory arbiter.
package miriscv_mem_arb_pkg;

    // Default datapath width of the core.
    localparam int ARB_XLEN = 32;

    // Arbitration policies.
    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    // Encoding doubles as the bit index into the request/grant vectors.
    typedef enum logic {
        REQ_FETCH,
        REQ_LSU
    } req_id_e;

    // Converts a one-hot grant vector into the requester id.
    function automatic req_id_e onehot_to_id(input logic [1:0] gnt);
        return gnt[1] ? REQ_LSU : REQ_FETCH;
    endfunction

endpackage

// File: rtl/miriscv_mem_arbiter_if.sv
// Requester and memory bus signals seen by the arbiter.
// slave: the arbiter's view; master: the environment (fetch, LSU, memory).
interface miriscv_mem_arbiter_if
    import miriscv_mem_arb_pkg::*;
#(
    parameter int XLEN = miriscv_mem_arb_pkg::ARB_XLEN
) ();

    logic                fetch_req_i;
    logic [XLEN-1:0]     fetch_addr_i;
    logic                fetch_rvalid_o;

    logic                lsu_req_i;
    logic                lsu_we_i;
    logic [XLEN/8-1:0]   lsu_be_i;
    logic [XLEN-1:0]     lsu_addr_i;
    logic [XLEN-1:0]     lsu_wdata_i;
    logic                lsu_rvalid_o;

    logic [XLEN-1:0]     rdata_o;

    logic                mem_req_o;
    logic                mem_we_o;
    logic [XLEN/8-1:0]   mem_be_o;
    logic [XLEN-1:0]     mem_addr_o;
    logic [XLEN-1:0]     mem_wdata_o;
    logic                mem_rvalid_i;
    logic [XLEN-1:0]     mem_rdata_i;

    modport slave (
        input  fetch_req_i, fetch_addr_i,
        input  lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        input  mem_rvalid_i, mem_rdata_i,
        output fetch_rvalid_o, lsu_rvalid_o, rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output fetch_req_i, fetch_addr_i,
        output lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        output mem_rvalid_i, mem_rdata_i,
        input  fetch_rvalid_o, lsu_rvalid_o, rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/miriscv_mem_arbiter_arb2.sv
// Two-way combinational grant: bit 0 = fetch, bit 1 = LSU, one-hot result.
module miriscv_arb2
    import miriscv_mem_arb_pkg::*;
#(
    parameter int PRIORITY_MODE = PRIO_FIXED
) (
    input  logic [1:0] req,
    input  req_id_e    last_id,
    output logic [1:0] gnt
);

    // A single requester always wins; ties resolve by policy.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            if (PRIORITY_MODE == PRIO_RR) begin
                gnt = (last_id == REQ_LSU) ? 2'b01 : 2'b10;
            end else begin
                gnt = 2'b10;
            end
        end
    end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares a single-port memory between instruction fetch and the LSU.
// The winning command is registered, held on the memory bus until the
// response returns, and the response is routed back to its owner unless
// the owner abandoned the request meanwhile.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ARB_IDLE | no transaction outstanding; arbitrate and capture a command
// ARB_BUSY | command on the memory bus; waiting for mem_rvalid_i
module miriscv_mem_arbiter
    import miriscv_mem_arb_pkg::*;
#(
    parameter int PRIORITY_MODE = PRIO_FIXED,
    parameter int XLEN          = miriscv_mem_arb_pkg::ARB_XLEN
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    miriscv_mem_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    req_id_e           gnt_id_q, gnt_id_d;
    req_id_e           last_id_q, last_id_d;
    logic              aborted_q, aborted_d;
    logic              cmd_we_q, cmd_we_d;
    logic [XLEN/8-1:0] cmd_be_q, cmd_be_d;
    logic [XLEN-1:0]   cmd_addr_q, cmd_addr_d;
    logic [XLEN-1:0]   cmd_wdata_q, cmd_wdata_d;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              owner_req;
    logic              mem_req;
    logic              fetch_rvalid;
    logic              lsu_rvalid;

    assign req       = {bus.lsu_req_i, bus.fetch_req_i};
    assign owner_req = (gnt_id_q == REQ_LSU) ? bus.lsu_req_i : bus.fetch_req_i;

    miriscv_arb2 #(
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_arb2 (
        .req     (req),
        .last_id (last_id_q),
        .gnt     (gnt)
    );

    // State, grant bookkeeping and command registers.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q     <= ARB_IDLE;
            gnt_id_q    <= REQ_FETCH;
            last_id_q   <= REQ_LSU;
            aborted_q   <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_be_q    <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            last_id_q   <= last_id_d;
            aborted_q   <= aborted_d;
            cmd_we_q    <= cmd_we_d;
            cmd_be_q    <= cmd_be_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

    // Next-state, command capture and response routing.
    always_comb begin
        state_d      = state_q;
        gnt_id_d     = gnt_id_q;
        last_id_d    = last_id_q;
        aborted_d    = aborted_q;
        cmd_we_d     = cmd_we_q;
        cmd_be_d     = cmd_be_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        mem_req      = 1'b0;
        fetch_rvalid = 1'b0;
        lsu_rvalid   = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                // A stray mem_rvalid_i here is deliberately ignored.
                if (|req) begin
                    state_d   = ARB_BUSY;
                    gnt_id_d  = onehot_to_id(gnt);
                    aborted_d = 1'b0;
                    if (gnt[1]) begin
                        cmd_we_d    = bus.lsu_we_i;
                        cmd_be_d    = bus.lsu_be_i;
                        cmd_addr_d  = bus.lsu_addr_i;
                        cmd_wdata_d = bus.lsu_wdata_i;
                    end else begin
                        cmd_we_d    = 1'b0;
                        cmd_be_d    = '1;
                        cmd_addr_d  = bus.fetch_addr_i;
                        cmd_wdata_d = '0;
                    end
                end
            end

            ARB_BUSY: begin
                // Drop the request in the response cycle so memory never
                // sees a second command before the grant is re-evaluated.
                mem_req = ~bus.mem_rvalid_i;
                if (bus.mem_rvalid_i) begin
                    if (gnt_id_q == REQ_LSU) begin
                        lsu_rvalid = ~aborted_q & bus.lsu_req_i;
                    end else begin
                        fetch_rvalid = ~aborted_q & bus.fetch_req_i;
                    end
                    last_id_d = gnt_id_q;
                    state_d   = ARB_IDLE;
                end else if (!owner_req) begin
                    // Sticky: a re-asserted request after a kill is a new
                    // request and must win arbitration again. An abandoned
                    // write still lands in memory.
                    aborted_d = 1'b1;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign bus.mem_req_o      = mem_req;
    assign bus.mem_we_o       = cmd_we_q;
    assign bus.mem_be_o       = cmd_be_q;
    assign bus.mem_addr_o     = cmd_addr_q;
    assign bus.mem_wdata_o    = cmd_wdata_q;
    assign bus.fetch_rvalid_o = fetch_rvalid;
    assign bus.lsu_rvalid_o   = lsu_rvalid;
    assign bus.rdata_o        = bus.mem_rdata_i;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Scoreboard bench: stimulus pushes expected memory commands and responses,
// negedge monitors pop and compare whenever the DUT presents them.
module tb_miriscv_mem_arbiter;
    import miriscv_mem_arb_pkg::*;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        lsu;
        logic [31:0] data;
    } resp_t;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    cmd_t  iss_q_a[$];
    cmd_t  iss_q_b[$];
    resp_t rsp_q_a[$];
    resp_t rsp_q_b[$];

    miriscv_mem_arbiter_if if_a ();
    miriscv_mem_arbiter_if if_b ();

    miriscv_mem_arbiter #(.PRIORITY_MODE(PRIO_FIXED)) dut_fix (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (if_a.slave)
    );

    miriscv_mem_arbiter #(.PRIORITY_MODE(PRIO_RR)) dut_rr (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk_cmd(input logic we, input logic [3:0] be,
                                    input logic [31:0] addr, input logic [31:0] wdata);
        cmd_t c;
        c.we = we; c.be = be; c.addr = addr; c.wdata = wdata;
        return c;
    endfunction

    function automatic resp_t mk_rsp(input logic lsu, input logic [31:0] data);
        resp_t r;
        r.lsu = lsu; r.data = data;
        return r;
    endfunction

    // Monitor for the fixed-priority instance.
    logic prev_req_a = 1'b0;
    always @(negedge clk) begin : mon_a
        cmd_t  c;
        resp_t r;
        if (if_a.mem_req_o && !prev_req_a) begin
            if (iss_q_a.size() == 0) begin
                check("issue_a_unexpected", if_a.mem_req_o, 1'b0);
            end else begin
                c = iss_q_a.pop_front();
                check("issue_a_cmd", {if_a.mem_we_o, if_a.mem_be_o, if_a.mem_addr_o, if_a.mem_wdata_o}, c);
            end
        end
        prev_req_a = if_a.mem_req_o;
        if (if_a.fetch_rvalid_o || if_a.lsu_rvalid_o) begin
            if (rsp_q_a.size() == 0) begin
                check("resp_a_unexpected", {if_a.lsu_rvalid_o, if_a.fetch_rvalid_o}, 2'b00);
            end else begin
                r = rsp_q_a.pop_front();
                check("resp_a_id", {if_a.lsu_rvalid_o, if_a.fetch_rvalid_o}, r.lsu ? 2'b10 : 2'b01);
                check("resp_a_data", if_a.rdata_o, r.data);
            end
        end
    end

    // Monitor for the round-robin instance.
    logic prev_req_b = 1'b0;
    always @(negedge clk) begin : mon_b
        cmd_t  c;
        resp_t r;
        if (if_b.mem_req_o && !prev_req_b) begin
            if (iss_q_b.size() == 0) begin
                check("issue_b_unexpected", if_b.mem_req_o, 1'b0);
            end else begin
                c = iss_q_b.pop_front();
                check("issue_b_cmd", {if_b.mem_we_o, if_b.mem_be_o, if_b.mem_addr_o, if_b.mem_wdata_o}, c);
            end
        end
        prev_req_b = if_b.mem_req_o;
        if (if_b.fetch_rvalid_o || if_b.lsu_rvalid_o) begin
            if (rsp_q_b.size() == 0) begin
                check("resp_b_unexpected", {if_b.lsu_rvalid_o, if_b.fetch_rvalid_o}, 2'b00);
            end else begin
                r = rsp_q_b.pop_front();
                check("resp_b_id", {if_b.lsu_rvalid_o, if_b.fetch_rvalid_o}, r.lsu ? 2'b10 : 2'b01);
                check("resp_b_data", if_b.rdata_o, r.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic req_of(input bit sel);
        return sel ? if_b.mem_req_o : if_a.mem_req_o;
    endfunction

    task automatic wait_issue(input bit sel, input string name);
        int n = 0;
        while (!req_of(sel) && n < 20) begin
            tick();
            n++;
        end
        check(name, req_of(sel), 1'b1);
    endtask

    // Pulse mem_rvalid_i; mem_req_o must already be low in that cycle.
    task automatic resp_start(input bit sel, input logic [31:0] data);
        if (sel) begin if_b.mem_rvalid_i = 1'b1; if_b.mem_rdata_i = data; end
        else     begin if_a.mem_rvalid_i = 1'b1; if_a.mem_rdata_i = data; end
        #1;
        check("req_falls_on_rvalid", req_of(sel), 1'b0);
    endtask

    task automatic resp_end(input bit sel);
        tick();
        if (sel) if_b.mem_rvalid_i = 1'b0;
        else     if_a.mem_rvalid_i = 1'b0;
    endtask

    // Called in the first cycle the command is on the bus.
    task automatic respond(input bit sel, input int lat, input logic [31:0] data);
        repeat (lat) tick();
        resp_start(sel, data);
        resp_end(sel);
    endtask

    task automatic set_lsu(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if_a.lsu_req_i = req; if_a.lsu_we_i = we; if_a.lsu_be_i = be;
        if_a.lsu_addr_i = addr; if_a.lsu_wdata_i = wdata;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        if_a.fetch_req_i = 0; if_a.fetch_addr_i = 0; if_a.mem_rvalid_i = 0; if_a.mem_rdata_i = 0;
        if_b.fetch_req_i = 0; if_b.fetch_addr_i = 0; if_b.mem_rvalid_i = 0; if_b.mem_rdata_i = 0;
        set_lsu(0, 0, 4'h0, 0, 0);
        if_b.lsu_req_i = 0; if_b.lsu_we_i = 0; if_b.lsu_be_i = 0; if_b.lsu_addr_i = 0; if_b.lsu_wdata_i = 0;

        // Reset state
        repeat (3) tick();
        check("rst_mem_req",   if_a.mem_req_o, 1'b0);
        check("rst_mem_we",    if_a.mem_we_o, 1'b0);
        check("rst_mem_be",    if_a.mem_be_o, 4'h0);
        check("rst_mem_addr",  if_a.mem_addr_o, 32'h0);
        check("rst_mem_wdata", if_a.mem_wdata_o, 32'h0);
        check("rst_frvalid",   if_a.fetch_rvalid_o, 1'b0);
        check("rst_lrvalid",   if_a.lsu_rvalid_o, 1'b0);
        arstn = 1'b1;
        tick();

        // Single fetch, memory latency 2
        if_a.fetch_req_i = 1; if_a.fetch_addr_i = 32'h100;
        iss_q_a.push_back(mk_cmd(0, 4'hF, 32'h100, 0));
        rsp_q_a.push_back(mk_rsp(0, 32'hCAFE_0100));
        #1 check("t1_idle_no_req", if_a.mem_req_o, 1'b0);
        tick();
        check("t1_latency", if_a.mem_req_o, 1'b1);
        respond(0, 2, 32'hCAFE_0100);
        if_a.fetch_req_i = 0;
        tick();

        // Fixed priority: LSU write beats fetch
        if_a.fetch_req_i = 1; if_a.fetch_addr_i = 32'h104;
        set_lsu(1, 1, 4'b0011, 32'h200, 32'h0000_A5A5);
        iss_q_a.push_back(mk_cmd(1, 4'b0011, 32'h200, 32'h0000_A5A5));
        iss_q_a.push_back(mk_cmd(0, 4'hF, 32'h104, 0));
        rsp_q_a.push_back(mk_rsp(1, 32'h1111_1111));
        rsp_q_a.push_back(mk_rsp(0, 32'h2222_2222));
        tick();
        check("t2_lsu_issue", if_a.mem_req_o, 1'b1);
        respond(0, 1, 32'h1111_1111);
        set_lsu(0, 0, 4'h0, 0, 0);
        check("t2_gap_cycle", if_a.mem_req_o, 1'b0);
        tick();
        check("t2_fetch_issue", if_a.mem_req_o, 1'b1);
        respond(0, 1, 32'h2222_2222);
        if_a.fetch_req_i = 0;
        tick();

        // Kill: LSU load abandoned, response absorbed
        set_lsu(1, 0, 4'hF, 32'h300, 32'hDEAD_BEEF);
        iss_q_a.push_back(mk_cmd(0, 4'hF, 32'h300, 32'hDEAD_BEEF));
        tick();
        set_lsu(0, 0, 4'h0, 0, 0);
        repeat (3) tick();
        resp_start(0, 32'h3333_3333);
        check("t3_kill_lrvalid", if_a.lsu_rvalid_o, 1'b0);
        check("t3_kill_frvalid", if_a.fetch_rvalid_o, 1'b0);
        resp_end(0);
        if_a.fetch_req_i = 1; if_a.fetch_addr_i = 32'h400;
        iss_q_a.push_back(mk_cmd(0, 4'hF, 32'h400, 0));
        rsp_q_a.push_back(mk_rsp(0, 32'h4444_4444));
        tick();
        check("t3_next_fetch", if_a.mem_req_o, 1'b1);
        respond(0, 1, 32'h4444_4444);
        if_a.fetch_req_i = 0;
        tick();

        // Abandon then re-assert before the response: dropped, re-arbitrated
        set_lsu(1, 0, 4'hF, 32'h310, 32'h0);
        iss_q_a.push_back(mk_cmd(0, 4'hF, 32'h310, 0));
        tick();
        if_a.lsu_req_i = 0;
        tick();
        if_a.lsu_req_i = 1;
        tick();
        resp_start(0, 32'h5555_5555);
        check("t3b_reassert_dropped", if_a.lsu_rvalid_o, 1'b0);
        iss_q_a.push_back(mk_cmd(0, 4'hF, 32'h310, 0));
        rsp_q_a.push_back(mk_rsp(1, 32'h6666_6666));
        resp_end(0);
        check("t3b_no_grant_resp_cycle", if_a.mem_req_o, 1'b0);
        wait_issue(0, "t3b_rearb_issue");
        respond(0, 1, 32'h6666_6666);
        set_lsu(0, 0, 4'h0, 0, 0);
        tick();

        // Spurious response while idle
        if_a.mem_rvalid_i = 1; if_a.mem_rdata_i = 32'h7777_7777;
        #1;
        check("t4_spur_frvalid", if_a.fetch_rvalid_o, 1'b0);
        check("t4_spur_lrvalid", if_a.lsu_rvalid_o, 1'b0);
        check("t4_rdata_bcast",  if_a.rdata_o, 32'h7777_7777);
        tick();
        if_a.mem_rvalid_i = 0;
        check("t4_spur_no_req", if_a.mem_req_o, 1'b0);
        tick();

        // Reset in the middle of a transaction
        if_a.fetch_req_i = 1; if_a.fetch_addr_i = 32'h500;
        iss_q_a.push_back(mk_cmd(0, 4'hF, 32'h500, 0));
        tick();
        check("t5_busy", if_a.mem_req_o, 1'b1);
        arstn = 0; if_a.fetch_req_i = 0;
        tick();
        arstn = 1;
        check("t5_rst_req",  if_a.mem_req_o, 1'b0);
        check("t5_rst_addr", if_a.mem_addr_o, 32'h0);
        tick();
        if_a.mem_rvalid_i = 1; if_a.mem_rdata_i = 32'h8888_8888;
        #1;
        check("t5_stray_frvalid", if_a.fetch_rvalid_o, 1'b0);
        check("t5_stray_lrvalid", if_a.lsu_rvalid_o, 1'b0);
        tick();
        if_a.mem_rvalid_i = 0;
        check("t5_stray_no_req", if_a.mem_req_o, 1'b0);
        if_a.fetch_req_i = 1; if_a.fetch_addr_i = 32'h504;
        iss_q_a.push_back(mk_cmd(0, 4'hF, 32'h504, 0));
        rsp_q_a.push_back(mk_rsp(0, 32'h9999_9999));
        wait_issue(0, "t5_after_rst_issue");
        respond(0, 1, 32'h9999_9999);
        if_a.fetch_req_i = 0;
        tick();

        // Round-robin with both requesting: FETCH, LSU, FETCH, LSU
        if_b.fetch_req_i = 1; if_b.fetch_addr_i = 32'h800;
        if_b.lsu_req_i = 1; if_b.lsu_we_i = 0; if_b.lsu_be_i = 4'hF;
        if_b.lsu_addr_i = 32'h900; if_b.lsu_wdata_i = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) iss_q_b.push_back(mk_cmd(0, 4'hF, 32'h800, 0));
            else            iss_q_b.push_back(mk_cmd(0, 4'hF, 32'h900, 0));
            rsp_q_b.push_back(mk_rsp(k % 2 == 1, 32'hB000_0000 + k));
            wait_issue(1, "t6_rr_issue");
            respond(1, 1, 32'hB000_0000 + k);
        end
        if_b.fetch_req_i = 0; if_b.lsu_req_i = 0;
        repeat (3) tick();

        check("end_iss_q_a_empty", iss_q_a.size(), 0);
        check("end_rsp_q_a_empty", rsp_q_a.size(), 0);
        check("end_iss_q_b_empty", iss_q_b.size(), 0);
        check("end_rsp_q_b_empty", rsp_q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
